// File: rtl/nano6502_pkg.sv
// Shared nano6502 peripheral definitions: interrupt register map, source indices
// and the vector encoding helper.
package nano6502_pkg;

  localparam int unsigned IRQ_DATA_W = 8;
  localparam int unsigned IRQ_ADDR_W = 2;
  localparam int unsigned IRQ_IDX_W  = 3;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_PEND = 2'd0;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_EN   = 2'd1;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_ACT  = 2'd2;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_REG_VEC  = 2'd3;

  localparam int unsigned IRQ_SRC_TIMER   = 0;
  localparam int unsigned IRQ_SRC_UART_RX = 1;
  localparam int unsigned IRQ_SRC_UART_TX = 2;

  localparam logic [IRQ_DATA_W-1:0] IRQ_VEC_NONE = 8'h80;

  // Vector byte: index of the winning source, or the "none" code when idle.
  function automatic logic [IRQ_DATA_W-1:0] irq_vector(input logic valid,
                                                       input logic [IRQ_IDX_W-1:0] idx);
    return valid ? IRQ_DATA_W'(idx) : IRQ_VEC_NONE;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder over an 8-bit request vector.
module irq_prio_enc
  import nano6502_pkg::*;
(
  input  logic [IRQ_DATA_W-1:0] i_req,
  output logic                  o_valid,
  output logic [IRQ_IDX_W-1:0]  o_idx
);

  // Scan from the top down so the lowest-numbered request is written last.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    for (int i = IRQ_DATA_W - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IRQ_IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: edge-detected sources latch into pending bits,
// masked by an enable register, driving the active-low 6502 IRQ line.
module irq_ctrl
  import nano6502_pkg::*;
#(
  parameter int unsigned          N_SRC    = 8,
  parameter logic [IRQ_DATA_W-1:0] EDGE_POL = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  R_W_n,
  input  logic [IRQ_ADDR_W-1:0] reg_addr_i,
  input  logic [IRQ_DATA_W-1:0] data_i,
  input  logic                  irq_cs,
  output logic [IRQ_DATA_W-1:0] data_o,
  input  logic [N_SRC-1:0]      src_i,
  output logic                  irq_n_o
);

  localparam logic [N_SRC-1:0] POL = EDGE_POL[N_SRC-1:0];

  logic [N_SRC-1:0]      r_src_q;
  logic [N_SRC-1:0]      r_pend;
  logic [N_SRC-1:0]      r_en;
  logic [N_SRC-1:0]      w_evt;
  logic [N_SRC-1:0]      w_wdata;
  logic [N_SRC-1:0]      w_set;
  logic [N_SRC-1:0]      w_clr;
  logic                  w_wr;
  logic [IRQ_DATA_W-1:0] w_act;
  logic                  w_vec_valid;
  logic [IRQ_IDX_W-1:0]  w_vec_idx;
  logic                  w_unused_data;

  assign w_wdata       = data_i[N_SRC-1:0];
  assign w_unused_data = ^data_i;
  assign w_wr          = irq_cs & ~R_W_n;

  // Per-bit polarity: rising where POL=1, falling where POL=0.
  assign w_evt = (src_i & ~r_src_q & POL) | (~src_i & r_src_q & ~POL);

  assign w_set = w_evt | ({N_SRC{w_wr && (reg_addr_i == IRQ_REG_ACT)}} & w_wdata);
  assign w_clr = {N_SRC{w_wr && (reg_addr_i == IRQ_REG_PEND)}} & w_wdata;

  assign w_act = IRQ_DATA_W'(r_pend & r_en);

  irq_prio_enc u_prio_enc (
    .i_req   (w_act),
    .o_valid (w_vec_valid),
    .o_idx   (w_vec_idx)
  );

  // Set has priority over clear so a coincident event is never dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_src_q <= POL;
      r_pend  <= '0;
      r_en    <= '0;
      irq_n_o <= 1'b1;
    end else begin
      r_src_q <= src_i;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      if (w_wr && (reg_addr_i == IRQ_REG_EN)) r_en <= w_wdata;
      irq_n_o <= ~|(r_pend & r_en);
    end
  end

  always_comb begin
    data_o = '0;
    case (reg_addr_i)
      IRQ_REG_PEND: data_o = IRQ_DATA_W'(r_pend);
      IRQ_REG_EN:   data_o = IRQ_DATA_W'(r_en);
      IRQ_REG_ACT:  data_o = w_act;
      IRQ_REG_VEC:  data_o = irq_vector(w_vec_valid, w_vec_idx);
      default:      data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: two instances (8 rising sources; 6 sources with
// bit 0 falling) checked every cycle against a behavioural model plus literals.
module tb_irq_ctrl;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rw     = 1'b1;
  logic       cs     = 1'b0;
  logic [1:0] addr   = 2'd0;
  logic [7:0] wdata  = 8'h00;
  logic [7:0] src_a  = 8'h01;
  logic [5:0] src_b  = 6'h00;
  logic [7:0] dout_a;
  logic [7:0] dout_b;
  logic       irq_a;
  logic       irq_b;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  irq_ctrl #(.N_SRC(8), .EDGE_POL(8'hFF)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .R_W_n(rw), .reg_addr_i(addr), .data_i(wdata),
    .irq_cs(cs), .data_o(dout_a), .src_i(src_a), .irq_n_o(irq_a)
  );

  irq_ctrl #(.N_SRC(6), .EDGE_POL(8'hFE)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .R_W_n(rw), .reg_addr_i(addr), .data_i(wdata),
    .irq_cs(cs), .data_o(dout_b), .src_i(src_b), .irq_n_o(irq_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: index 0 = u_dut_a, 1 = u_dut_b.
  logic [7:0] m_pend [2];
  logic [7:0] m_en   [2];
  logic [7:0] m_prev [2];
  logic       m_irq  [2];
  logic [7:0] m_pol  [2] = '{8'hFF, 8'hFE};
  logic [7:0] m_mask [2] = '{8'hFF, 8'h3F};

  function automatic logic [7:0] src_of(input int d);
    return (d == 0) ? src_a : {2'b00, src_b};
  endfunction

  function automatic logic [7:0] nxt_pend(input int d);
    logic [7:0] cur = src_of(d);
    logic [7:0] p   = m_pend[d];
    logic       wr  = cs && !rw;
    for (int b = 0; b < 8; b++) begin
      if (m_mask[d][b]) begin
        logic ev;
        ev = m_pol[d][b] ? (cur[b] && !m_prev[d][b]) : (!cur[b] && m_prev[d][b]);
        if (ev || (wr && addr == 2'd2 && wdata[b])) p[b] = 1'b1;
        else if (wr && addr == 2'd0 && wdata[b])   p[b] = 1'b0;
      end
    end
    return p;
  endfunction

  function automatic logic [7:0] nxt_en(input int d);
    return (cs && !rw && addr == 2'd1) ? (wdata & m_mask[d]) : m_en[d];
  endfunction

  function automatic logic [7:0] mread(input int d, input logic [1:0] a);
    logic [7:0] act = m_pend[d] & m_en[d];
    case (a)
      2'd0: return m_pend[d];
      2'd1: return m_en[d];
      2'd2: return act;
      default: begin
        for (int b = 0; b < 8; b++) if (act[b]) return 8'(b);
        return 8'h80;
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_pend[d] <= 8'h00;
        m_en[d]   <= 8'h00;
        m_irq[d]  <= 1'b1;
        m_prev[d] <= m_pol[d] & m_mask[d];
      end else begin
        m_irq[d]  <= ((m_pend[d] & m_en[d]) == 8'h00);
        m_pend[d] <= nxt_pend(d);
        m_en[d]   <= nxt_en(d);
        m_prev[d] <= src_of(d);
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_irq_a", 8'(irq_a), 8'(m_irq[0]));
      chk("model_irq_b", 8'(irq_b), 8'(m_irq[1]));
      chk("model_rd_a", dout_a, mread(0, addr));
      chk("model_rd_b", dout_b, mread(1, addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; wdata = d;
    cyc();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    addr = a;
    #1;
    chk(nm, dout_a, e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;

    // Reset state with timer idle high
    rd(2'd0, 8'h00, "rst_pend");
    chk("rst_irq", 8'(irq_a), 8'h01);
    rd(2'd3, 8'h80, "rst_vec");
    cyc();
    rd(2'd0, 8'h00, "no_edge_after_release");

    // Timer run then expire
    wr(2'd1, 8'h01);
    src_a = 8'h00; cyc();
    src_a = 8'h01; cyc();
    rd(2'd0, 8'h01, "timer_pend");
    chk("irq_not_yet", 8'(irq_a), 8'h01);
    cyc();
    chk("irq_low", 8'(irq_a), 8'h00);
    rd(2'd3, 8'h00, "vec_timer");

    // W1C clears, IRQ releases a cycle later
    wr(2'd0, 8'h01);
    rd(2'd0, 8'h00, "w1c_pend");
    cyc();
    chk("irq_released", 8'(irq_a), 8'h01);

    // W1C coincident with a new rising edge: set wins
    src_a = 8'h00; cyc();
    src_a = 8'h01; cyc();
    cyc();
    chk("irq_low_again", 8'(irq_a), 8'h00);
    src_a = 8'h00; cyc();
    cs = 1'b1; rw = 1'b0; addr = 2'd0; wdata = 8'h01; src_a = 8'h01;
    cyc();
    cs = 1'b0; rw = 1'b1;
    rd(2'd0, 8'h01, "set_beats_clr");
    cyc();
    chk("irq_stays_low", 8'(irq_a), 8'h00);
    wr(2'd0, 8'h01);
    cyc();
    chk("irq_high_after_clr", 8'(irq_a), 8'h01);

    // Software set while masked, then enable one bit
    wr(2'd1, 8'h00);
    wr(2'd2, 8'h24);
    rd(2'd0, 8'h24, "sw_set_pend");
    cyc();
    chk("masked_irq_high", 8'(irq_a), 8'h01);
    wr(2'd1, 8'h20);
    chk("irq_at_en_edge", 8'(irq_a), 8'h01);
    cyc();
    chk("irq_after_en", 8'(irq_a), 8'h00);
    rd(2'd2, 8'h20, "active");
    rd(2'd3, 8'h05, "vec5");

    // Mask deasserts IRQ, bit stays pending
    wr(2'd1, 8'h00);
    cyc();
    chk("mask_irq_high", 8'(irq_a), 8'h01);
    rd(2'd0, 8'h24, "mask_keeps_pend");

    // Fill everything, then async reset mid-operation
    wr(2'd2, 8'hFF);
    rd(2'd0, 8'hFF, "all_pend");
    chk("b_upper_ignored", dout_b, 8'h3F);
    wr(2'd1, 8'hFF);
    cyc();
    chk("irq_full", 8'(irq_a), 8'h00);
    rst_n = 1'b0;
    #1;
    chk("rst_irq_a_async", 8'(irq_a), 8'h01);
    chk("rst_irq_b_async", 8'(irq_b), 8'h01);
    rd(2'd0, 8'h00, "rst_mid_pend");
    rd(2'd1, 8'h00, "rst_mid_en");
    cyc();
    rd(2'd2, 8'h00, "rst_mid_act");
    rd(2'd3, 8'h80, "rst_mid_vec");
    cyc();
    rst_n = 1'b1;
    cyc();
    rd(2'd0, 8'h00, "post_rst_no_edge");

    // Falling-edge source on the second instance
    src_b = 6'h01; cyc();
    addr = 2'd0; #1;
    chk("b_rise_ignored", dout_b, 8'h00);
    src_b = 6'h00; cyc();
    chk("b_fall_sets", dout_b, 8'h01);
    src_b = 6'h02; cyc();
    chk("b_bit1_rise", dout_b, 8'h03);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Bus-mapped interrupt controller sitting downstream of the nano6502 peripherals (timer, UART, etc.). It consumes their status levels (e.g. timer idle, which rises when a countdown expires) and turns the selected edges into latched pending bits. It applies an enable mask and drives the 6502 active-low IRQ line. Register interface matches the other peripherals: 2-bit address, chip select and R_W_n, with a combinational read mux.

Parameters:
N_SRC, 8, number of interrupt sources (1..8); bits at or above N_SRC read 0 and ignore writes.
EDGE_POL, 8'hFF, per-source edge select: 1 = rising edge sets pending, 0 = falling edge sets pending.

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
R_W_n  input  1  CPU bus direction: 1 = read, 0 = write
reg_addr_i  input  2  register select
data_i  input  8  CPU write data
irq_cs  input  1  chip select from address decoder
data_o  output  8  read data (combinational from reg_addr_i)
src_i  input  N_SRC  interrupt source levels, synchronous to clk_i (bit 0 = timer idle)
irq_n_o  output  1  registered active-low IRQ to CPU

Behaviour:
- Reset: rst_n_i is asynchronous, active-low; clock is clk_i. On reset:
  - pending = 0, enable = 0, irq_n_o = 1.
  - src_q = EDGE_POL, so sources already at their "event" level out of reset (timer idle = 1) raise nothing.
- Edge detect: src_q <= src_i every cycle. The per-bit event is:
  - rising (EDGE_POL = 1): src_i & ~src_q;
  - falling (EDGE_POL = 0): ~src_i & src_q.
  - Pending is set on the same clock edge at which the event is detected.
- Register map:
  - 00 R: pending. W: write-1-to-clear pending bits.
  - 01 R/W: enable mask.
  - 02 R: active = pending & enable. W: write-1-to-set pending (software trigger).
  - 03 R: vector. bit7 = 1 when no active bit, else 0; bits2:0 = index of the lowest-numbered active bit; bits6:3 = 0. W: ignored.
- Write strobe is irq_cs & ~R_W_n, sampled every cycle it is asserted. Repeated strobes are idempotent.
- Reads have no side effects.
- Pending update per bit, in priority order:
  1. set if event OR software-set;
  2. else clear if W1C;
  3. else hold.
- Set wins over clear in the same cycle, so no event is lost.
- irq_n_o <= ~|(pending & enable), one cycle after pending/enable change.
- Latency: event on edge N sets pending at edge N; irq_n_o falls at edge N+1.
- IRQ is level: it stays low until all active bits are cleared or masked.
- Enabling an already-pending bit asserts IRQ one cycle after the enable write.
- Masking a bit deasserts IRQ next cycle, but the bit stays pending.
- Reset mid-operation: all state returns to reset values immediately (async). No edges are detected on the first cycle after release because src_q = EDGE_POL.
- Data bits at or above N_SRC: read 0, writes ignored.

Decomposition:
- Shared package nano6502_pkg:
  - register address constants IRQ_REG_PEND = 2'd0, IRQ_REG_EN = 2'd1, IRQ_REG_ACT = 2'd2, IRQ_REG_VEC = 2'd3;
  - source index constants (IRQ_SRC_TIMER = 0, IRQ_SRC_UART_RX = 1, ...);
  - IRQ_VEC_NONE = 8'h80.
- One sub-module is natural: irq_prio_enc (8-bit lowest-set-bit encoder producing valid + 3-bit index), reusable by a future NMI/vector block.

Test Plan:
- Reset with src_i = 8'h01 (timer idle), EDGE_POL = FF -> pending = 00, irq_n_o = 1, reg 03 reads 80.
- Enable = 01; drive src_i[0] 1->0->1 (timer run then expire) -> pending = 01 at the rising edge, irq_n_o = 0 one cycle later, reg 03 reads 00.
- W1C 01 to reg 00 -> pending = 00, irq_n_o = 1 next cycle. Repeat, but with a src_i[0] rising edge in the same cycle as the W1C -> pending stays 01 and IRQ stays low.
- Enable = 00; software set 0x24 via reg 02 -> pending = 24, irq_n_o stays 1. Then enable = 20 -> irq_n_o = 0 one cycle after the write, reg 02 reads 20, reg 03 reads 05.
- EDGE_POL = FE; src_i[0] falling edge -> pending[0] set; rising edge -> no change.
- Assert rst_n_i while pending = FF, enable = FF, IRQ low -> irq_n_o = 1 immediately; all registers read 00 except reg 03, which reads 80.
